boot_loader: RTL and testbench

//   Upstream feeder for the 8-bit cpu: receives a framed byte stream (from a UART rx or bench),

---
 rtl/boot_loader_pkg.sv | 22 ++
 rtl/boot_loader.sv | 161 ++++++++++++++++
 tb/tb_boot_loader.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/boot_loader_pkg.sv
// Shared definitions for the boot loader: FSM state encoding and default framing constants.
package boot_loader_pkg;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StAddr = 3'd1,
    StLen  = 3'd2,
    StData = 3'd3,
    StCsum = 3'd4,
    StWait = 3'd5,
    StRun  = 3'd6
  } state_e;

  localparam logic [7:0]  SyncByteDefault = 8'hA5;
  localparam int unsigned RunDelayDefault = 2;

  // True while a frame is being received (after SYNC, up to and including CSUM).
  function automatic logic state_loading(state_e s);
    return (s == StAddr) || (s == StLen) || (s == StData) || (s == StCsum);
  endfunction

endpackage

// File: rtl/boot_loader.sv
// Frame receiver that loads a payload into cpu memory and releases cpu reset once the frame's
// checksum verifies; returns to idle when the cpu halts.
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE = SyncByteDefault,
  parameter int unsigned RUN_DELAY = RunDelayDefault
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       cpu_reset,
  input  logic       cpu_halt,
  output logic       loading,
  output logic       err,
  output logic [7:0] frames_ok
);

  localparam int unsigned DlyW = (RUN_DELAY > 1) ? $clog2(RUN_DELAY) : 1;
  localparam logic [DlyW-1:0] DlyLast = DlyW'(RUN_DELAY - 1);

  state_e          state_q, state_d;
  logic [7:0]      ptr_q, ptr_d;
  logic [8:0]      cnt_q, cnt_d;
  logic [7:0]      sum_q, sum_d;
  logic [DlyW-1:0] dly_q, dly_d;
  logic            mem_we_q, mem_we_d;
  logic [7:0]      mem_addr_q, mem_addr_d;
  logic [7:0]      mem_wdata_q, mem_wdata_d;
  logic            cpu_reset_q, cpu_reset_d;
  logic            err_q, err_d;
  logic [7:0]      frames_q, frames_d;

  logic       xfer;
  logic [7:0] sum_add;

  assign in_ready  = (state_q != StWait) && (state_q != StRun);
  assign loading   = state_loading(state_q);
  assign xfer      = in_valid & in_ready;
  assign sum_add   = sum_q + in_data;

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_reset = cpu_reset_q;
  assign err       = err_q;
  assign frames_ok = frames_q;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    dly_d       = dly_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_reset_d = cpu_reset_q;
    err_d       = err_q;
    frames_d    = frames_q;

    unique case (state_q)
      StIdle: begin
        if (xfer && (in_data == SYNC_BYTE)) begin
          state_d = StAddr;
          err_d   = 1'b0;
          sum_d   = 8'h00;
        end
      end
      StAddr: begin
        if (xfer) begin
          ptr_d   = in_data;
          sum_d   = sum_add;
          state_d = StLen;
        end
      end
      StLen: begin
        if (xfer) begin
          // A zero length byte encodes a full 256-byte payload.
          cnt_d   = (in_data == 8'h00) ? 9'd256 : {1'b0, in_data};
          sum_d   = sum_add;
          state_d = StData;
        end
      end
      StData: begin
        if (xfer) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = ptr_q;
          mem_wdata_d = in_data;
          ptr_d       = ptr_q + 8'd1;
          sum_d       = sum_add;
          cnt_d       = cnt_q - 9'd1;
          if (cnt_q == 9'd1) begin
            state_d = StCsum;
          end
        end
      end
      StCsum: begin
        if (xfer) begin
          if (sum_add == 8'h00) begin
            state_d  = StWait;
            frames_d = frames_q + 8'd1;
            dly_d    = '0;
          end else begin
            state_d = StIdle;
            err_d   = 1'b1;
          end
        end
      end
      StWait: begin
        if (dly_q == DlyLast) begin
          state_d     = StRun;
          cpu_reset_d = 1'b0;
        end else begin
          dly_d = dly_q + 1'b1;
        end
      end
      StRun: begin
        if (cpu_halt) begin
          state_d     = StIdle;
          cpu_reset_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      ptr_q       <= 8'h00;
      cnt_q       <= 9'd0;
      sum_q       <= 8'h00;
      dly_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 8'h00;
      mem_wdata_q <= 8'h00;
      cpu_reset_q <= 1'b1;
      err_q       <= 1'b0;
      frames_q    <= 8'h00;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      dly_q       <= dly_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_reset_q <= cpu_reset_d;
      err_q       <= err_d;
      frames_q    <= frames_d;
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: frame-level model checked against the DUT every cycle,
// plus literal memory-image and counter expectations.
module tb_boot_loader;

  typedef logic [7:0] bq_t[$];

  localparam int RunDelay = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       cpu_halt = 1'b0;
  logic       in_ready, mem_we, cpu_reset, loading, err;
  logic [7:0] mem_addr, mem_wdata, frames_ok;

  boot_loader #(
    .SYNC_BYTE (8'hA5),
    .RUN_DELAY (RunDelay)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_reset (cpu_reset),
    .cpu_halt  (cpu_halt),
    .loading   (loading),
    .err       (err),
    .frames_ok (frames_ok)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Frame-level model of the loader's visible outputs.
  bit         chk_en = 1'b0;
  bit         exp_ready = 1'b1;
  bit         exp_cpu_reset = 1'b1;
  bit         exp_loading = 1'b0;
  bit         exp_err = 1'b0;
  logic [7:0] exp_frames = 8'h00;
  bit         exp_we = 1'b0;
  logic [7:0] exp_addr = 8'h00;
  logic [7:0] exp_wdata = 8'h00;
  int         run_cnt = 0;
  bit         running = 1'b0;

  // Memory the cpu would see, filled only from the DUT's write port.
  logic [7:0] shadow [256];
  int         wr_count = 0;

  always @(posedge clk) begin
    if (mem_we) begin
      shadow[mem_addr] <= mem_wdata;
      wr_count         <= wr_count + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", in_ready, exp_ready);
      chk("mem_we", mem_we, exp_we);
      if (exp_we) begin
        chk("mem_addr", mem_addr, exp_addr);
        chk("mem_wdata", mem_wdata, exp_wdata);
      end
      chk("cpu_reset", cpu_reset, exp_cpu_reset);
      chk("loading", loading, exp_loading);
      chk("err", err, exp_err);
      chk("frames_ok", frames_ok, exp_frames);
    end
  end

  // One clock: drive inputs, take the edge, then advance the time-driven parts of the model.
  task automatic cyc(input logic v, input logic [7:0] d, input logic halt, output logic took);
    in_valid = v;
    in_data  = d;
    cpu_halt = halt;
    @(posedge clk);
    took = v & exp_ready;
    #1;
    exp_we = 1'b0;
    if (run_cnt > 0) begin
      run_cnt--;
      if (run_cnt == 0) begin
        exp_cpu_reset = 1'b0;
        running       = 1'b1;
      end
    end else if (running && halt) begin
      running       = 1'b0;
      exp_cpu_reset = 1'b1;
      exp_ready     = 1'b1;
    end
  endtask

  task automatic build(input logic [7:0] addr, input logic [7:0] len, input bq_t payload,
                       input bit corrupt, output bq_t fr);
    logic [7:0] s;
    s  = addr + len;
    fr = {8'hA5, addr, len};
    foreach (payload[i]) begin
      fr.push_back(payload[i]);
      s = s + payload[i];
    end
    fr.push_back((8'h00 - s) + (corrupt ? 8'h01 : 8'h00));
  endtask

  // Sends the first nsend bytes of a frame; with gaps, every byte is followed by an idle cycle
  // that carries a SYNC value on in_data.
  task automatic send_frame(input bq_t fr, input int nsend, input bit gaps);
    int         i;
    int         tries;
    int         len;
    logic       took;
    logic [7:0] s;
    logic [7:0] a;
    i     = 0;
    tries = 0;
    a     = fr[1];
    len   = (fr[2] == 8'h00) ? 256 : int'(fr[2]);
    s     = 8'h00;
    for (int j = 1; j < fr.size(); j++) s = s + fr[j];
    while (i < nsend) begin
      cyc(1'b1, fr[i], 1'b0, took);
      if (took) begin
        if (i == 0) begin
          exp_loading = 1'b1;
          exp_err     = 1'b0;
        end else if (i >= 3 && i < 3 + len) begin
          exp_we    = 1'b1;
          exp_addr  = a + 8'(i - 3);
          exp_wdata = fr[i];
        end else if (i == 3 + len) begin
          exp_loading = 1'b0;
          if (s == 8'h00) begin
            exp_frames = exp_frames + 8'd1;
            exp_ready  = 1'b0;
            run_cnt    = RunDelay;
          end else begin
            exp_err = 1'b1;
          end
        end
        i++;
        tries = 0;
      end else begin
        tries++;
        if (tries > 8) begin
          checks++;
          errors++;
          $display("FAIL send_timeout: byte %0d never accepted, ready %0b", i, in_ready);
          return;
        end
      end
      if (gaps && i < nsend) cyc(1'b0, 8'hA5, 1'b0, took);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_run();
    logic took;
    int   k;
    k = 0;
    while (!running && k < 12) begin
      cyc(1'b0, 8'h00, 1'b0, took);
      k++;
    end
    if (!running) begin
      checks++;
      errors++;
      $display("FAIL run_timeout: cpu_reset %0b expected 0", cpu_reset);
    end
  endtask

  task automatic run_and_halt();
    logic took;
    wait_run();
    cyc(1'b0, 8'h00, 1'b1, took);
    cyc(1'b0, 8'h00, 1'b0, took);
  endtask

  // Entered just after a rising edge; reset is asserted mid-cycle and checked before any edge.
  task automatic do_reset();
    chk_en   = 1'b0;
    in_valid = 1'b0;
    cpu_halt = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 8'h00);
    chk("rst_mem_wdata", mem_wdata, 8'h00);
    chk("rst_cpu_reset", cpu_reset, 1'b1);
    chk("rst_loading", loading, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_frames_ok", frames_ok, 8'h00);
    exp_ready     = 1'b1;
    exp_cpu_reset = 1'b1;
    exp_loading   = 1'b0;
    exp_err       = 1'b0;
    exp_frames    = 8'h00;
    exp_we        = 1'b0;
    run_cnt       = 0;
    running       = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
  endtask

  bq_t  f1, f1_bad, f3, f4, fw, pl;
  logic took;
  int   wc0;

  initial begin
    pl = {8'h63, 8'h73, 8'h04, 8'hE0, 8'h02, 8'h01};
    build(8'h00, 8'h06, pl, 1'b0, f1);
    build(8'h00, 8'h06, pl, 1'b1, f1_bad);
    pl = {8'h11, 8'h22, 8'h33};
    build(8'hFE, 8'h03, pl, 1'b0, f3);
    pl = {};
    for (int i = 0; i < 256; i++) pl.push_back(8'(i));
    build(8'h00, 8'h00, pl, 1'b0, f4);

    @(posedge clk);
    #1;
    do_reset();

    // Good frame; the generated checksum must match the hand-computed one.
    chk("f1_csum_byte", f1[9], 8'h3D);
    send_frame(f1, f1.size(), 1'b0);
    run_and_halt();
    chk("s1_mem0", shadow[0], 8'h63);
    chk("s1_mem1", shadow[1], 8'h73);
    chk("s1_mem2", shadow[2], 8'h04);
    chk("s1_mem3", shadow[3], 8'hE0);
    chk("s1_mem4", shadow[4], 8'h02);
    chk("s1_mem5", shadow[5], 8'h01);
    chk("s1_frames", frames_ok, 8'd1);

    // Bad checksum, then recovery.
    do_reset();
    chk("f1_bad_csum_byte", f1_bad[9], 8'h3E);
    send_frame(f1_bad, f1_bad.size(), 1'b0);
    cyc(1'b0, 8'h00, 1'b0, took);
    cyc(1'b0, 8'h00, 1'b0, took);
    chk("s2_err", err, 1'b1);
    chk("s2_cpu_reset", cpu_reset, 1'b1);
    chk("s2_ready", in_ready, 1'b1);
    send_frame(f1, f1.size(), 1'b0);
    chk("s2_err_cleared", err, 1'b0);
    run_and_halt();
    chk("s2_frames", frames_ok, 8'd1);

    // Address wrap.
    send_frame(f3, f3.size(), 1'b0);
    run_and_halt();
    chk("s3_memFE", shadow[8'hFE], 8'h11);
    chk("s3_memFF", shadow[8'hFF], 8'h22);
    chk("s3_mem00", shadow[8'h00], 8'h33);

    // Full 256-byte payload.
    wc0 = wr_count;
    send_frame(f4, f4.size(), 1'b0);
    run_and_halt();
    chk("s4_writes", wr_count - wc0, 256);
    chk("s4_csum_byte", f4[259], 8'h80);
    chk("s4_mem80", shadow[8'h80], 8'h80);
    chk("s4_memFF", shadow[8'hFF], 8'hFF);

    // Leading garbage and gapped valid.
    do_reset();
    cyc(1'b1, 8'h12, 1'b0, took);
    cyc(1'b1, 8'h34, 1'b0, took);
    chk("s5_idle_loading", loading, 1'b0);
    wc0 = wr_count;
    send_frame(f1, f1.size(), 1'b1);
    run_and_halt();
    chk("s5_writes", wr_count - wc0, 6);
    chk("s5_mem0", shadow[0], 8'h63);
    chk("s5_mem3", shadow[3], 8'hE0);
    chk("s5_mem5", shadow[5], 8'h01);
    chk("s5_frames", frames_ok, 8'd1);

    // Reset mid-DATA, then mid-RUN, then a normal load.
    send_frame(f1, 5, 1'b0);
    do_reset();
    send_frame(f1, f1.size(), 1'b0);
    wait_run();
    chk("s6_running", cpu_reset, 1'b0);
    do_reset();
    send_frame(f3, f3.size(), 1'b0);
    run_and_halt();
    chk("s6_frames", frames_ok, 8'd1);
    chk("s6_memFF", shadow[8'hFF], 8'h22);

    // frames_ok wraparound; data values include the SYNC byte.
    do_reset();
    for (int k = 0; k < 256; k++) begin
      pl = {8'(k)};
      build(8'h10, 8'h01, pl, 1'b0, fw);
      send_frame(fw, fw.size(), 1'b0);
      run_and_halt();
      if (k == 8'hA5) chk("s7_sync_as_data", shadow[8'h10], 8'hA5);
    end
    chk("s7_frames_wrap", frames_ok, 8'h00);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
